// File: rtl/decoder_pipe.sv
// Registered 3-to-8 one-hot decoder behind a 2-entry valid/ready FIFO, with a wrapping delivered-word counter.
// Optional build macro DEC_HOLD_EN: o0..o7 keep the last delivered word while out_valid=0.
module decoder_pipe #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             i0,
  input  logic             i1,
  input  logic             i2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             o0,
  output logic             o1,
  output logic             o2,
  output logic             o3,
  output logic             o4,
  output logic             o5,
  output logic             o6,
  output logic             o7,
  output logic [CNT_W-1:0] dec_cnt
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // in_ready is registered, so it never depends combinationally on out_ready.
  logic [2:0]       mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       occ;
  logic [1:0]       occ_next;
  logic             in_ready_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       code;
  logic             push;
  logic             pop;
  logic [7:0]       head_word;
  logic [7:0]       word;

  assign code      = {i2, i1, i0};
  assign in_ready  = in_ready_q;
  assign out_valid = (occ != 2'd0);
  assign push      = in_valid & in_ready_q;
  assign pop       = out_valid & out_ready;
  assign head_word = 8'd1 << mem[rd_ptr];

  always_comb begin
    occ_next = occ;
    if (push && !pop) begin
      occ_next = occ + 2'd1;
    end else if (pop && !push) begin
      occ_next = occ - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0]     <= 3'd0;
      mem[1]     <= 3'd0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      occ        <= 2'd0;
      in_ready_q <= 1'b1;
      cnt_q      <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= code;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
        cnt_q  <= cnt_q + 1'b1;
      end
      occ        <= occ_next;
      in_ready_q <= (occ_next != 2'd2);
    end
  end

`ifdef DEC_HOLD_EN
  logic [7:0] held_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_q <= 8'h00;
    end else if (pop) begin
      held_q <= head_word;
    end
  end

  assign word = out_valid ? head_word : held_q;
`else
  assign word = out_valid ? head_word : 8'h00;
`endif

  assign {o7, o6, o5, o4, o3, o2, o1, o0} = word;
  assign dec_cnt = cnt_q;

endmodule

// File: tb/tb_decoder_pipe.sv
// Directed bench for decoder_pipe: reset, sweep, backpressure, simultaneous push/pop,
// counter wrap and mid-operation reset.
module tb_decoder_pipe;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] code;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] o;
  logic [7:0] dec_cnt;

  int n_checks = 0;
  int n_errors = 0;
  logic [2:0] prev_code;
  logic [2:0] rnd_code;

  decoder_pipe #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .i0        (code[0]),
    .i1        (code[1]),
    .i2        (code[2]),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .o0        (o[0]),
    .o1        (o[1]),
    .o2        (o[2]),
    .o3        (o[3]),
    .o4        (o[4]),
    .o5        (o[5]),
    .o6        (o[6]),
    .o7        (o[7]),
    .dec_cnt   (dec_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected o0..o7 while out_valid=0, given the last word delivered.
  function automatic logic [7:0] idle_word(input logic [7:0] last);
`ifdef DEC_HOLD_EN
    return last;
`else
    return 8'h00;
`endif
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; code = 3'd0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;

    // 1 Reset asserted mid-cycle with a word pending
    in_valid = 1'b1; code = 3'd4;
    step();
    in_valid = 1'b0;
    check("pre_reset_valid", out_valid, 1);
    check("pre_reset_o", o, 8'h10);
    rst = 1'b1;
    #1;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_o", o, 8'h00);
    check("reset_cnt", dec_cnt, 0);
    rst = 1'b0;
    step();
    check("reset_still_empty", out_valid, 0);

    // 2 Sweep with out_ready held high
    out_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      in_valid = 1'b1; code = 3'(j);
      step();
      check("sweep_valid", out_valid, 1);
      check("sweep_o", o, 32'(8'h01 << j));
      check("sweep_in_ready", in_ready, 1);
    end
    in_valid = 1'b0;
    step();
    check("sweep_drain_valid", out_valid, 0);
    check("sweep_drain_o", o, idle_word(8'h80));
    check("sweep_cnt", dec_cnt, 8);

    // 3 Backpressure: fill, blocked push, then release
    out_ready = 1'b0;
    in_valid = 1'b1; code = 3'd3;
    step();
    check("bp_first_o", o, 8'h08);
    check("bp_first_in_ready", in_ready, 1);
    code = 3'd5;
    step();
    check("bp_full_in_ready", in_ready, 0);
    check("bp_full_o", o, 8'h08);
    code = 3'd7;
    step();
    in_valid = 1'b0;
    check("bp_blocked_o", o, 8'h08);
    check("bp_blocked_in_ready", in_ready, 0);
    step();
    check("bp_hold_o", o, 8'h08);
    out_ready = 1'b1;
    step();
    check("bp_second_o", o, 8'h20);
    check("bp_second_valid", out_valid, 1);
    check("bp_in_ready_back", in_ready, 1);
    step();
    check("bp_drained_valid", out_valid, 0);
    check("bp_drained_o", o, idle_word(8'h20));
    check("bp_cnt", dec_cnt, 10);

    // 4 Simultaneous push and pop at occupancy 1
    out_ready = 1'b0;
    in_valid = 1'b1; code = 3'd2;
    step();
    check("sim_first_o", o, 8'h04);
    out_ready = 1'b1; code = 3'd6;
    step();
    in_valid = 1'b0;
    check("sim_next_o", o, 8'h40);
    check("sim_valid", out_valid, 1);
    check("sim_in_ready", in_ready, 1);
    check("sim_cnt", dec_cnt, 11);
    step();
    check("sim_drained_valid", out_valid, 0);
    check("sim_cnt_after", dec_cnt, 12);

    // 5 Counter wrap: 244 more transfers take dec_cnt from 12 through 255 to 0
    prev_code = 3'd0;
    for (int k = 0; k < 244; k++) begin
      rnd_code = 3'($urandom_range(0, 7));
      in_valid = 1'b1; code = rnd_code;
      step();
      check("wrap_o", o, 32'(8'h01 << rnd_code));
      prev_code = rnd_code;
    end
    in_valid = 1'b0;
    check("wrap_cnt_255", dec_cnt, 255);
    step();
    check("wrap_cnt_0", dec_cnt, 0);
    check("wrap_idle_o", o, idle_word(8'h01 << prev_code));

    // 6 Mid-operation reset with two entries buffered
    out_ready = 1'b0;
    in_valid = 1'b1; code = 3'd1;
    step();
    code = 3'd4;
    step();
    in_valid = 1'b0;
    check("mid_full_in_ready", in_ready, 0);
    check("mid_full_o", o, 8'h02);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check("mid_out_valid", out_valid, 0);
    check("mid_in_ready", in_ready, 1);
    check("mid_o", o, 8'h00);
    check("mid_cnt", dec_cnt, 0);
    out_ready = 1'b1;
    step();
    check("mid_no_stale_valid", out_valid, 0);
    check("mid_no_stale_o", o, 8'h00);
    step();
    check("mid_no_stale_cnt", dec_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
